// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: word width, NOP encoding, fetch states and PC step.
package rv32_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic {
        FS_RUN,
        FS_DRAIN
    } fetch_state_e;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/ifetch_buffer_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and decode handshake.
interface ifetch_buffer_if
    import rv32_pkg::*;
;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/ifb_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush and occupancy count; head read straight from storage flops.
module ifb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch stage: credit-limited sequential reads, prefetch FIFO, redirect flush/drain.
// Optional IFB_BYPASS_EN: a response may skip an empty FIFO straight to decode in the same cycle.
module ifetch_buffer
    import rv32_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    ifetch_buffer_if.master bus
);
    localparam int          CW           = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic            req_valid_q, req_valid_d;

    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   tag_pc;
    logic [CW-1:0]     data_count, tag_count, data_count_next;
    logic              accept, rsp_take, live_rsp, bypass, push, pop;

    // Request valid is registered, so credit is judged on next-cycle occupancy and outstanding reads.
    always_comb begin
        accept   = req_valid_q && bus.imem_req_ready;
        rsp_take = bus.imem_rsp_valid && (outstanding_q != '0);
        live_rsp = rsp_take && (state_q == FS_RUN) && !bus.redirect_valid && (tag_count != '0);
        pop      = (data_count != '0) && bus.instr_ready;
`ifdef IFB_BYPASS_EN
        bypass   = live_rsp && (data_count == '0) && bus.instr_ready;
`else
        bypass   = 1'b0;
`endif
        push          = live_rsp && !bypass;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_take);

        if (bus.redirect_valid) begin
            data_count_next = '0;
        end else begin
            data_count_next = data_count + CW'(push) - CW'(pop);
        end

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = (outstanding_d != '0) ? FS_DRAIN : FS_RUN;
        end else if ((state_q == FS_DRAIN) && (outstanding_d == '0)) begin
            state_d = FS_RUN;
        end

        req_valid_d = (state_d == FS_RUN) &&
                      (({1'b0, data_count_next} + {1'b0, outstanding_d}) < CREDIT_LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FS_RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            req_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= req_valid_d;
        end
    end

    // Issue tags: a read accepted in a redirect cycle is never tagged, it only drains.
    ifb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (accept && !bus.redirect_valid),
        .din   (fetch_pc_q),
        .pop   (live_rsp),
        .dout  (tag_pc),
        .count (tag_count)
    );

    ifb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .din   ({bus.imem_rsp_data, tag_pc}),
        .pop   (pop),
        .dout  (head),
        .count (data_count)
    );

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = fetch_pc_q;

`ifdef IFB_BYPASS_EN
    assign bus.instr_valid = bypass || (data_count != '0);
    assign bus.instr       = bypass ? bus.imem_rsp_data : head[2*XLEN-1:XLEN];
    assign bus.instr_pc    = bypass ? tag_pc : head[XLEN-1:0];
`else
    assign bus.instr_valid = (data_count != '0);
    assign bus.instr       = head[2*XLEN-1:XLEN];
    assign bus.instr_pc    = head[XLEN-1:0];
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: directed fetch/redirect scenarios plus randomized traffic.
module tb_ifetch_buffer;
    import rv32_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFB_BYPASS_EN
    localparam bit BYPASS          = 1'b1;
    localparam int EXP_FIRST_VALID = 2;
`else
    localparam bit BYPASS          = 1'b0;
    localparam int EXP_FIRST_VALID = 3;
`endif

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_buffer_if bus ();

    ifetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: reads in flight, words held for decode, next request and next delivery PCs.
    pend_t       pend[$];
    logic [31:0] acc_log[$];
    logic [31:0] fetch_pc, exp_pc;
    int          held, stale_cnt, cyc, accepts, first_iv_cyc;
    int          p_req_ready, p_instr_ready, lat_min, lat_max;
    int          tests_run = 0;
    int          tests_failed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveInputs();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = ($urandom_range(99) < p_req_ready);
        bus.instr_ready    = ($urandom_range(99) < p_instr_ready);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst                = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("rst_req_addr", bus.imem_req_addr, 32'h0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_instr", bus.instr, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        rst = 1'b1;
        pend.delete();
        acc_log.delete();
        fetch_pc     = 32'h0;
        exp_pc       = 32'h0;
        held         = 0;
        stale_cnt    = 0;
        cyc          = 0;
        accepts      = 0;
        first_iv_cyc = -1;
        driveInputs();
    endtask

    // One clock: check outputs against the model, advance the model on the edge, drive next inputs.
    task automatic applyStimulus();
        bit          acc, popd, rsp, redir, exp_req, exp_iv;
        logic [31:0] rpc;
        int          live;
        pend_t       p;
        #1;
        live  = pend.size() - stale_cnt;
        acc   = bus.imem_req_valid && bus.imem_req_ready;
        popd  = bus.instr_valid && bus.instr_ready;
        rsp   = bus.imem_rsp_valid && (pend.size() > 0);
        redir = bus.redirect_valid;
        rpc   = bus.redirect_pc;
        if (cyc > 0) begin
            exp_req = (stale_cnt == 0) && (held + live < DEPTH);
            checkOutput("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        end
        if (bus.imem_req_valid) checkOutput("req_addr", bus.imem_req_addr, fetch_pc);
        exp_iv = (held > 0);
        if (BYPASS && rsp && held == 0 && stale_cnt == 0 && bus.instr_ready && !redir) exp_iv = 1'b1;
        checkOutput("instr_valid", 32'(bus.instr_valid), 32'(exp_iv));
        if (bus.instr_valid) begin
            if (first_iv_cyc < 0) first_iv_cyc = cyc;
            checkOutput("instr_pc", bus.instr_pc, exp_pc);
            checkOutput("instr", bus.instr, mem_word(exp_pc));
        end
        @(posedge clk);
        cyc++;
        if (rsp) begin
            p = pend.pop_front();
            if (p.stale) stale_cnt--;
            else         held++;
        end
        if (popd) begin
            held--;
            exp_pc += 32'd4;
        end
        if (acc) begin
            pend.push_back('{fetch_pc, 1'b0, cyc + $urandom_range(lat_max, lat_min) - 1});
            acc_log.push_back(fetch_pc);
            fetch_pc += 32'd4;
            accepts++;
        end
        if (redir) begin
            foreach (pend[i]) begin
                if (!pend[i].stale) begin
                    pend[i].stale = 1'b1;
                    stale_cnt++;
                end
            end
            held     = 0;
            fetch_pc = rpc & ~32'h3;
            exp_pc   = rpc & ~32'h3;
        end
        #1;
        driveInputs();
        @(negedge clk);
    endtask

    task automatic setKnobs(input int rr, input int ir, input int lmin, input int lmax);
        p_req_ready   = rr;
        p_instr_ready = ir;
        lat_min       = lmin;
        lat_max       = lmax;
    endtask

    initial begin
        int guard;
        setKnobs(100, 100, 1, 1);

        // Streaming from reset with single-cycle memory
        applyReset();
        repeat (20) applyStimulus();
        checkOutput("first_valid_cycle", 32'(first_iv_cyc), 32'(EXP_FIRST_VALID));
        checkOutput("stream_progress", 32'(exp_pc > 32'h20), 32'd1);

        // Decode stalled: credit limits to DEPTH accepts, then resumes at 0x10
        setKnobs(100, 0, 1, 1);
        applyReset();
        repeat (12) applyStimulus();
        checkOutput("stall_accepts", 32'(accepts), 32'd4);
        checkOutput("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("stall_instr_pc", bus.instr_pc, 32'h0);
        p_instr_ready   = 100;
        bus.instr_ready = 1'b1;
        guard = 0;
        while (accepts < 5 && guard < 10) begin
            applyStimulus();
            guard++;
        end
        checkOutput("resume_accepts", 32'(accepts), 32'd5);
        checkOutput("resume_addr", (acc_log.size() > 4) ? acc_log[4] : 32'hx, 32'h10);

        // Redirect with two reads outstanding
        setKnobs(100, 100, 6, 6);
        applyReset();
        guard = 0;
        while (pend.size() < 2 && guard < 10) begin
            applyStimulus();
            guard++;
        end
        checkOutput("two_outstanding", 32'(pend.size()), 32'd2);
        p_req_ready        = 0;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        applyStimulus();
        acc_log.delete();
        p_req_ready = 100;
        repeat (25) applyStimulus();
        checkOutput("redir_first_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hx, 32'h100);
        checkOutput("redir_delivered", 32'(exp_pc > 32'h100), 32'd1);

        // Redirect near the top of the address space wraps to zero
        setKnobs(100, 100, 1, 1);
        repeat (5) applyStimulus();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        applyStimulus();
        acc_log.delete();
        repeat (15) applyStimulus();
        checkOutput("wrap_addr0", (acc_log.size() > 0) ? acc_log[0] : 32'hx, 32'hFFFF_FFF8);
        checkOutput("wrap_addr1", (acc_log.size() > 1) ? acc_log[1] : 32'hx, 32'hFFFF_FFFC);
        checkOutput("wrap_addr2", (acc_log.size() > 2) ? acc_log[2] : 32'hx, 32'h0000_0000);

        // Unaligned redirect coinciding with a response
        setKnobs(100, 100, 2, 2);
        guard = 0;
        while (!bus.imem_rsp_valid && guard < 10) begin
            applyStimulus();
            guard++;
        end
        checkOutput("rsp_present", 32'(bus.imem_rsp_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        applyStimulus();
        acc_log.delete();
        repeat (15) applyStimulus();
        checkOutput("unaligned_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hx, 32'h200);

        // Reset in mid-traffic, then a stray response with nothing outstanding
        setKnobs(100, 60, 1, 3);
        repeat (10) applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("midrst_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("midrst_req_addr", bus.imem_req_addr, 32'h0);
        applyReset();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        applyStimulus();
        checkOutput("stray_ignored", 32'(bus.instr_valid), 32'd0);
        repeat (15) applyStimulus();

        // Randomized traffic with occasional redirects
        for (int seg = 0; seg < 30; seg++) begin
            setKnobs($urandom_range(100, 30), $urandom_range(100, 20), 1, $urandom_range(5, 1));
            for (int n = 0; n < 100; n++) begin
                if ($urandom_range(99) < 4) begin
                    bus.redirect_valid = 1'b1;
                    case ($urandom_range(2))
                        0:       bus.redirect_pc = $urandom;
                        1:       bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                        default: bus.redirect_pc = 32'($urandom_range(255));
                    endcase
                end
                applyStimulus();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
